csi2_hdr_ecc_ctrl: RTL and testbench

CSI2_HDR_ECC_CTRL -- requirements
Module: csi2_hdr_ecc_ctrl

---
 rtl/csi2_hdr_ecc_ctrl.sv | 158 +++++++++++++++
 tb/tb_csi2_hdr_ecc_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_hdr_ecc_ctrl.sv
// CSI-2 packet header ECC checker/corrector: two-stage pipeline (syndrome, then fix + re-encode)
// with valid/ready handshakes on both sides and saturating error counters.
module csi2_hdr_ecc_ctrl #(
    parameter int CNT_W       = 16,
    parameter bit DROP_UNCORR = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             hdr_valid_i,
    output logic             hdr_ready_o,
    input  logic [31:0]      hdr_data_i,
    output logic             hdr_valid_o,
    input  logic             hdr_ready_i,
    output logic [31:0]      hdr_data_o,
    output logic             hdr_corr_o,
    output logic             hdr_err_o,
    input  logic             cnt_clear_i,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic [CNT_W-1:0] uncorr_cnt_o
);

    // Syndrome contributed by each header data bit D0..D23 (parity bits P5..P0).
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] e;
        e = '0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e ^= ECC_COL[i];
        end
        return e;
    endfunction

    // Syndrome to failing data bit position; 31 means "not a single data-bit error".
    function automatic logic [4:0] err_bit_pos(input logic [5:0] syn);
        logic [4:0] p;
        p = 5'd31;
        for (int i = 0; i < 24; i++) begin
            if (syn == ECC_COL[i]) p = 5'(i);
        end
        return p;
    endfunction

    logic             rdy_en_q, rdy_en_d;
    logic             s1_valid_q, s1_valid_d;
    logic [23:0]      s1_data_q, s1_data_d;
    logic [5:0]       s1_syn_q, s1_syn_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic             s2_corr_q, s2_corr_d;
    logic             s2_err_q, s2_err_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic        s1_load;
    logic        s2_load;
    logic        s2_go;
    logic [4:0]  err_pos;
    logic [23:0] fix_data;
    logic        fix_corr;
    logic        fix_err;
    logic        unused_ecc_hi;

    assign unused_ecc_hi = ^hdr_data_i[31:30];

    always_comb begin
        rdy_en_d = 1'b1;

        // A dropped uncorrectable beat leaves stage 2 without waiting for downstream.
        s2_go       = s2_valid_q && (hdr_ready_i || (DROP_UNCORR && s2_err_q));
        s2_load     = s1_valid_q && (!s2_valid_q || s2_go);
        hdr_ready_o = rdy_en_q && (!s1_valid_q || s2_load);
        s1_load     = hdr_valid_i && hdr_ready_o;

        s1_valid_d = s1_load || (s1_valid_q && !s2_load);
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        if (s1_load) begin
            s1_data_d = hdr_data_i[23:0];
            s1_syn_d  = ecc_calc(hdr_data_i[23:0]) ^ hdr_data_i[29:24];
        end

        err_pos  = err_bit_pos(s1_syn_q);
        fix_data = s1_data_q;
        fix_corr = 1'b0;
        fix_err  = 1'b0;
        if (s1_syn_q == 6'd0) begin
            fix_corr = 1'b0;
        end else if (err_pos <= 5'd23) begin
            fix_data = s1_data_q ^ (24'd1 << err_pos);
            fix_corr = 1'b1;
        end else if ($onehot(s1_syn_q)) begin
            fix_corr = 1'b1;
        end else begin
            fix_err = 1'b1;
        end

        s2_valid_d = s2_load || (s2_valid_q && !s2_go);
        s2_data_d  = s2_data_q;
        s2_corr_d  = s2_corr_q;
        s2_err_d   = s2_err_q;
        if (s2_load) begin
            s2_data_d = {2'b00, ecc_calc(fix_data), fix_data};
            s2_corr_d = fix_corr;
            s2_err_d  = fix_err;
        end

        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clear_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (s2_go && s2_corr_q && (corr_cnt_q != '1))
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            if (s2_go && s2_err_q && (uncorr_cnt_q != '1))
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdy_en_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_corr_q    <= 1'b0;
            s2_err_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            rdy_en_q     <= rdy_en_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_corr_q    <= s2_corr_d;
            s2_err_q     <= s2_err_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign hdr_valid_o  = s2_valid_q && !(DROP_UNCORR && s2_err_q);
    assign hdr_data_o   = s2_data_q;
    assign hdr_corr_o   = s2_corr_q;
    assign hdr_err_o    = s2_err_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_csi2_hdr_ecc_ctrl.sv
// Scoreboard bench for csi2_hdr_ecc_ctrl: main instance plus a drop-mode and a 4-bit-counter instance.
module tb_csi2_hdr_ecc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_corr, out_err, clr;
    logic [31:0] in_data, out_data;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_corr, d_out_err;
    logic [31:0] d_in_data, d_out_data;
    logic [15:0] d_corr_cnt, d_uncorr_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_corr, s_out_err, s_clr;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_corr_cnt, s_uncorr_cnt;

    csi2_hdr_ecc_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .hdr_valid_i(in_valid), .hdr_ready_o(in_ready), .hdr_data_i(in_data),
        .hdr_valid_o(out_valid), .hdr_ready_i(out_ready), .hdr_data_o(out_data),
        .hdr_corr_o(out_corr), .hdr_err_o(out_err), .cnt_clear_i(clr),
        .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
    );

    csi2_hdr_ecc_ctrl #(.CNT_W(16), .DROP_UNCORR(1'b1)) dut_drop (
        .clk_i(clk), .rst_n_i(rst_n),
        .hdr_valid_i(d_in_valid), .hdr_ready_o(d_in_ready), .hdr_data_i(d_in_data),
        .hdr_valid_o(d_out_valid), .hdr_ready_i(1'b1), .hdr_data_o(d_out_data),
        .hdr_corr_o(d_out_corr), .hdr_err_o(d_out_err), .cnt_clear_i(1'b0),
        .corr_cnt_o(d_corr_cnt), .uncorr_cnt_o(d_uncorr_cnt)
    );

    csi2_hdr_ecc_ctrl #(.CNT_W(4), .DROP_UNCORR(1'b0)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n),
        .hdr_valid_i(s_in_valid), .hdr_ready_o(s_in_ready), .hdr_data_i(s_in_data),
        .hdr_valid_o(s_out_valid), .hdr_ready_i(1'b1), .hdr_data_o(s_out_data),
        .hdr_corr_o(s_out_corr), .hdr_err_o(s_out_err), .cnt_clear_i(s_clr),
        .corr_cnt_o(s_corr_cnt), .uncorr_cnt_o(s_uncorr_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        corr;
        logic        err;
        int          stamp;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference ECC written as the six parity equations of the header code.
    function automatic logic [5:0] model_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Offer one header to the main DUT and queue its expected response once it is accepted.
    task automatic applyStimulus(input logic [31:0] din, input logic [31:0] exp_data,
                                 input logic exp_corr, input logic exp_err, input bit lat_chk);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = din;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.data  = exp_data;
            e.corr  = exp_corr;
            e.err   = exp_err;
            e.stamp = cyc;
            e.lat   = lat_chk;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        #2;
    endtask

    // Single beat into one of the auxiliary instances (0 = drop mode, 1 = 4-bit counters).
    task automatic driveAux(input int sel, input logic [31:0] din);
        int   waited;
        logic rdy;
        waited = 0;
        @(negedge clk);
        if (sel == 0) begin d_in_valid = 1'b1; d_in_data = din; end
        else begin s_in_valid = 1'b1; s_in_data = din; end
        #1;
        rdy = (sel == 0) ? d_in_ready : s_in_ready;
        while (!rdy && waited < 50) begin
            @(negedge clk);
            #1;
            rdy = (sel == 0) ? d_in_ready : s_in_ready;
            waited++;
        end
        checkOutput("aux_accept", 64'(rdy), 64'd1);
        @(negedge clk);
        d_in_valid = 1'b0;
        s_in_valid = 1'b0;
    endtask

    logic        held_v = 1'b0;
    logic [33:0] held_val;

    always begin
        @(negedge clk);
        #2;
        if (out_valid) begin
            if (held_v)
                checkOutput("hold_stable", 64'({out_err, out_corr, out_data}), 64'(held_val));
            if (out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got 0x%0h want none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
                    checkOutput("out_corr", 64'(out_corr), 64'(e.corr));
                    checkOutput("out_err", 64'(out_err), 64'(e.err));
                    if (e.lat) checkOutput("latency", 64'(cyc - e.stamp), 64'd2);
                end
            end else begin
                held_v   = 1'b1;
                held_val = {out_err, out_corr, out_data};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    int          d_seen = 0;
    logic [31:0] d_last = '0;
    logic        d_last_corr = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (d_out_valid) begin
            d_seen++;
            d_last      = d_out_data;
            d_last_corr = d_out_corr;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    logic [31:0] hdr0;
    logic [23:0] dbl;
    logic [23:0] bd;
    logic [31:0] bh;
    int          n;

    initial begin
        in_valid = 0; in_data = '0; out_ready = 1; clr = 0;
        d_in_valid = 0; d_in_data = '0;
        s_in_valid = 0; s_in_data = '0; s_clr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        hdr0 = {2'b00, model_ecc(24'h09602B), 24'h09602B};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_flags", 64'({out_corr, out_err}), 64'd0);
        checkOutput("rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
        checkOutput("rst_aux_ready", 64'({d_in_ready, s_in_ready}), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

        applyStimulus(hdr0, hdr0, 1'b0, 1'b0, 1'b1);
        applyStimulus(hdr0 | 32'hC000_0000, hdr0, 1'b0, 1'b0, 1'b1);
        idle();
        drain();
        checkOutput("clean_corr_cnt", 64'(corr_cnt), 64'd0);
        checkOutput("clean_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

        for (int k = 0; k < 24; k++)
            applyStimulus(hdr0 ^ (32'd1 << k), hdr0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        checkOutput("bit_corr_cnt", 64'(corr_cnt), 64'd24);
        checkOutput("bit_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

        applyStimulus(hdr0 ^ (32'd1 << 27), hdr0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        checkOutput("ecc_bit_corr_cnt", 64'(corr_cnt), 64'd25);

        dbl = hdr0[23:0] ^ 24'h000204;
        applyStimulus({hdr0[31:24], dbl}, {2'b00, model_ecc(dbl), dbl}, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        checkOutput("double_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
        checkOutput("double_corr_cnt", 64'(corr_cnt), 64'd25);

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bd = 24'h123400 + 24'(i * 273);
                    bh = {2'b00, model_ecc(bd), bd};
                    if (i == 3) applyStimulus(bh ^ 32'h0000_2000, bh, 1'b1, 1'b0, 1'b0);
                    else applyStimulus(bh, bh, 1'b0, 1'b0, 1'b0);
                end
                idle();
            end
            begin
                @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                checkOutput("bp_ready_low", 64'(in_ready), 64'd0);
                checkOutput("bp_valid_high", 64'(out_valid), 64'd1);
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("bp_corr_cnt", 64'(corr_cnt), 64'd26);

        driveAux(0, {hdr0[31:24], dbl});
        repeat (5) @(negedge clk);
        #3;
        checkOutput("drop_no_beat", 64'(d_seen), 64'd0);
        checkOutput("drop_uncorr_cnt", 64'(d_uncorr_cnt), 64'd1);
        driveAux(0, hdr0 ^ 32'h20);
        repeat (5) @(negedge clk);
        #3;
        checkOutput("drop_pass_beats", 64'(d_seen), 64'd1);
        checkOutput("drop_pass_data", 64'({d_last_corr, d_last}), 64'({1'b1, hdr0}));

        for (int i = 0; i < 20; i++) driveAux(1, hdr0 ^ (32'd1 << (i % 24)));
        repeat (4) @(negedge clk);
        #1;
        checkOutput("sat_corr_cnt", 64'(s_corr_cnt), 64'd15);
        checkOutput("sat_uncorr_cnt", 64'(s_uncorr_cnt), 64'd0);
        driveAux(1, hdr0 ^ 32'h1);
        n = 0;
        #1;
        while (!s_out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("sat_beat_out", 64'(s_out_valid), 64'd1);
        s_clr = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("clear_wins", 64'(s_corr_cnt), 64'd0);
        s_clr = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("clear_hold", 64'(s_corr_cnt), 64'd0);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = hdr0;
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_ready", 64'(in_ready), 64'd0);
        checkOutput("midrst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        checkOutput("midrst_no_out", 64'(out_valid), 64'd0);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
